master_start_sync: RTL and testbench
====================================

Name: master_start_sync

Overview:
- 48 MHz real-time synchronizer.
- Maintains the 64-bit system time and fetches timed commands from the real-time command register (wcm) via REQ_COMMAND/WR_DATA.
- Programs the chirp DDS over a 4-phase REQ/ACK handshake.
- At TIME_START, generates a burst of N emit (En_Iz) / receive (En_Pr) windows and gates DDS_start.

Parameters:
- TIME_W, 64, system time / start-time width.
- FREQ_W, 48, DDS frequency and frequency-step width.
- CNT_W, 32, DDS rate and interval counter width.

Ports:
- CLK  in  1  48 MHz clock.
- rst_n  in  1  asynchronous active-low reset.
- SYS_TIME  in  TIME_W  time value preloaded on the second mark.
- SYS_TIME_UPDATE  in  1  arms the time preload.
- T1hz  in  1  second mark, synchronous level.
- TIME  out  TIME_W  system time, counts CLK cycles.
- SYS_TIME_UPDATE_OK  out  1  one-cycle pulse when the preload happens.
- REQ_COMMAND  out  1  one-cycle request for the next command.
- WR_DATA  in  1  command-valid strobe; MEM_* are captured when high.
- MEM_DDS_freq, MEM_DDS_delta_freq  in  FREQ_W  DDS frequency and step.
- MEM_DDS_delta_rate  in  CNT_W  DDS rate.
- MEM_TIME_START  in  TIME_W  burst start time.
- MEM_N_impuls  in  16  number of impulses.
- MEM_TYPE_impulse  in  2  bit0: 1 = coherent, 0 = non-coherent.
- MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2  in  CNT_W  durations in CLK cycles.
- DDS_freq, DDS_delta_freq  out  FREQ_W  DDS setup.
- DDS_delta_rate  out  CNT_W  DDS setup.
- REQ  out  1  DDS setup request.
- ACK  in  1  DDS acknowledge; 2-FF synchronized internally.
- DDS_start  out  1  DDS run enable.
- En_Iz  out  1  emit window.
- En_Pr  out  1  receive window.

Behaviour:
- Reset: all outputs 0, TIME = 0, FSM in IDLE.
- Time counter:
  - TIME increments by 1 every cycle.
  - T1hz rising edge while SYS_TIME_UPDATE = 1: next cycle TIME = SYS_TIME, SYS_TIME_UPDATE_OK = 1 for one cycle.
  - A rising edge with SYS_TIME_UPDATE = 0 has no effect.
  - TIME wraps modulo 2^64.
- FSM states and transitions:
  - IDLE: pulse REQ_COMMAND one cycle, go to WAIT_CMD.
  - WAIT_CMD: on WR_DATA, latch all MEM_*. If N_impuls = 0, return to IDLE; else go to LOAD.
  - LOAD: drive DDS_* from the latch and raise REQ. Hold REQ and DDS_* stable until synced ACK = 1. Then drop REQ and wait for ACK = 0, then go to ARMED.
  - ARMED: when TIME >= TIME_START (unsigned), go to IZ; the compare re-evaluates after any time preload.
  - IZ: En_Iz = 1 for Interval_Ti cycles, then go to BL1.
  - BL1: Tblank1 cycles, then go to PR.
  - PR: En_Pr = 1 for Interval_Tp cycles, then go to BL2.
  - BL2: Tblank2 cycles. Then decrement the impulse count: if it is still nonzero go to IZ, else go to IDLE.
- Zero-duration phases are skipped without consuming a cycle of the next phase's count.
- Coherent mode (TYPE bit0 = 1): DDS_start = 1 from IZ entry of the first impulse to the end of the last BL2. The DDS is not reprogrammed between impulses.
- Non-coherent mode (TYPE bit0 = 0): DDS_start = En_Iz, so the DDS restarts each impulse.
- En_Iz and En_Pr are registered, never high together, and rise exactly 1 cycle after the start condition.
- WR_DATA outside WAIT_CMD is ignored.
- The next REQ_COMMAND is issued only after the burst ends.
- rst_n low mid-burst aborts immediately: outputs go to 0, REQ is released.

Optional Feature:
- Macro LATE_CMD_DROP_EN.
- Defined: a command with TIME_START < TIME at capture is discarded; the FSM goes back to IDLE and requests the next command, no DDS setup.
- Undefined: a late command runs (LOAD, then starts at once).

Decomposition:
- Package master_start_pkg: state enum, width localparams, TYPE bit index constant.
- One sub-module: ms_interval_timer (load, count down, done), reused for all four phases.

Test Plan:
- Time preload: SYS_TIME_UPDATE = 1, SYS_TIME = 0, T1hz edge at TIME = 0x5000 -> TIME = 0 the next cycle, SYS_TIME_UPDATE_OK pulsed 1 cycle; a second edge with SYS_TIME_UPDATE = 0 leaves TIME untouched.
- Coherent burst: FREQ 0x1000000000, STEP 0x100000, RATE 0x100, TIME_START 0x22C0, N = 2, TYPE = 1, Ti = Tp = 0x1800, Tblank1 = Tblank2 = 0x180 ->
  - REQ/ACK completes before start.
  - En_Iz rises at TIME 0x22C1 for 6144 cycles.
  - En_Pr follows 384 cycles after En_Iz falls.
  - Pattern repeats twice.
  - DDS_start stays high through the whole burst, then REQ_COMMAND pulses.
- Non-coherent: same command with TYPE = 0 -> DDS_start equals En_Iz exactly; no REQ between impulses.
- Handshake stall: hold ACK low 50 cycles -> REQ and DDS_* remain stable; ARMED not entered until ACK high then low.
- Late command, TIME_START 0x10 at TIME 0x9000 -> with LATE_CMD_DROP_EN no En_Iz and REQ_COMMAND re-pulses; without it En_Iz starts right after LOAD.
- Reset mid-IZ -> En_Iz, DDS_start, REQ are 0 asynchronously; after release the FSM issues REQ_COMMAND again.

Source files
------------

// File: rtl/master_start_pkg.sv
`default_nettype none
// ============================================================================
// Module  : master_start_pkg
// Brief   : Shared widths, FSM state encoding and phase helpers for the
//           48 MHz master start synchronizer.
// Revision: 1.0 - initial release
// ============================================================================
package master_start_pkg;

    localparam int c_TIME_W            = 64;
    localparam int c_FREQ_W            = 48;
    localparam int c_CNT_W             = 32;
    localparam int c_NIMP_W            = 16;
    localparam int c_TYPE_COHERENT_BIT = 0;

    // Phase indices within one impulse; c_PH_NONE marks "impulse finished".
    localparam logic [2:0] c_PH_IZ   = 3'd0;
    localparam logic [2:0] c_PH_BL1  = 3'd1;
    localparam logic [2:0] c_PH_PR   = 3'd2;
    localparam logic [2:0] c_PH_BL2  = 3'd3;
    localparam logic [2:0] c_PH_NONE = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_CMD = 4'd1,
        S_LOAD     = 4'd2,
        S_LOAD_REL = 4'd3,
        S_ARMED    = 4'd4,
        S_IZ       = 4'd5,
        S_BL1      = 4'd6,
        S_PR       = 4'd7,
        S_BL2      = 4'd8
    } ms_state_t;

    // First phase at or after 'from' whose duration is nonzero.
    function automatic logic [2:0] next_phase(input logic [3:0] nz_mask,
                                              input logic [2:0] from);
        logic [2:0] w_sel;
        w_sel = c_PH_NONE;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && nz_mask[i]) begin
                w_sel = 3'(i);
            end
        end
        return w_sel;
    endfunction

    function automatic ms_state_t phase_state(input logic [2:0] phase);
        case (phase)
            c_PH_IZ:  return S_IZ;
            c_PH_BL1: return S_BL1;
            c_PH_PR:  return S_PR;
            c_PH_BL2: return S_BL2;
            default:  return S_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] state_phase(input ms_state_t st);
        case (st)
            S_IZ:    return c_PH_IZ;
            S_BL1:   return c_PH_BL1;
            S_PR:    return c_PH_PR;
            S_BL2:   return c_PH_BL2;
            default: return c_PH_NONE;
        endcase
    endfunction

endpackage : master_start_pkg
`default_nettype wire

// File: rtl/ms_interval_timer.sv
`default_nettype none
// ============================================================================
// Module  : ms_interval_timer
// Brief   : Loadable down-counter; o_done is high in the last cycle of a
//           loaded interval. One instance times every burst phase.
// Revision: 1.0 - initial release
// ============================================================================
module ms_interval_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == CNT_W'(1));

endmodule : ms_interval_timer
`default_nettype wire

// File: rtl/master_start_sync.sv
`default_nettype none
// ============================================================================
// Module  : master_start_sync
// Brief   : 48 MHz real-time synchronizer: system time, command fetch, DDS
//           REQ/ACK setup and timed emit/receive burst generation.
//           Optional macro LATE_CMD_DROP_EN discards commands already late.
// Revision: 1.0 - initial release
// ============================================================================
module master_start_sync
    import master_start_pkg::*;
#(
    parameter int TIME_W = c_TIME_W,
    parameter int FREQ_W = c_FREQ_W,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic [TIME_W-1:0]   SYS_TIME,
    input  logic                SYS_TIME_UPDATE,
    input  logic                T1hz,
    output logic [TIME_W-1:0]   TIME,
    output logic                SYS_TIME_UPDATE_OK,
    output logic                REQ_COMMAND,
    input  logic                WR_DATA,
    input  logic [FREQ_W-1:0]   MEM_DDS_freq,
    input  logic [FREQ_W-1:0]   MEM_DDS_delta_freq,
    input  logic [CNT_W-1:0]    MEM_DDS_delta_rate,
    input  logic [TIME_W-1:0]   MEM_TIME_START,
    input  logic [c_NIMP_W-1:0] MEM_N_impuls,
    input  logic [1:0]          MEM_TYPE_impulse,
    input  logic [CNT_W-1:0]    MEM_Interval_Ti,
    input  logic [CNT_W-1:0]    MEM_Interval_Tp,
    input  logic [CNT_W-1:0]    MEM_Tblank1,
    input  logic [CNT_W-1:0]    MEM_Tblank2,
    output logic [FREQ_W-1:0]   DDS_freq,
    output logic [FREQ_W-1:0]   DDS_delta_freq,
    output logic [CNT_W-1:0]    DDS_delta_rate,
    output logic                REQ,
    input  logic                ACK,
    output logic                DDS_start,
    output logic                En_Iz,
    output logic                En_Pr
);

    // ------------------------------------------------------------------
    // System time
    // ------------------------------------------------------------------
    logic [TIME_W-1:0] r_time;
    logic              r_t1hz_d;
    logic              r_upd_ok;
    logic              w_t1hz_rise;

    assign w_t1hz_rise = T1hz & ~r_t1hz_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_time   <= '0;
            r_t1hz_d <= 1'b0;
            r_upd_ok <= 1'b0;
        end else begin
            r_t1hz_d <= T1hz;
            if (w_t1hz_rise && SYS_TIME_UPDATE) begin
                r_time   <= SYS_TIME;
                r_upd_ok <= 1'b1;
            end else begin
                r_time   <= r_time + TIME_W'(1);
                r_upd_ok <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ACK synchronizer
    // ------------------------------------------------------------------
    logic r_ack_meta;
    logic r_ack_sync;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= ACK;
            r_ack_sync <= r_ack_meta;
        end
    end

    // ------------------------------------------------------------------
    // Command latch, FSM and registered outputs
    // ------------------------------------------------------------------
    ms_state_t         r_state;
    logic [TIME_W-1:0] r_start;
    logic [c_NIMP_W-1:0] r_imp_left;
    logic              r_coherent;
    logic [CNT_W-1:0]  r_ti;
    logic [CNT_W-1:0]  r_tp;
    logic [CNT_W-1:0]  r_tb1;
    logic [CNT_W-1:0]  r_tb2;
    logic              r_req_command;
    logic [FREQ_W-1:0] r_dds_freq;
    logic [FREQ_W-1:0] r_dds_delta_freq;
    logic [CNT_W-1:0]  r_dds_delta_rate;
    logic              r_req;
    logic              r_dds_start;
    logic              r_en_iz;
    logic              r_en_pr;

    logic              w_late;
    logic              w_unused_type;
    logic [3:0]        w_nz;
    logic [2:0]        w_first;
    logic [2:0]        w_cur;
    logic [2:0]        w_after;
    logic              w_due;
    logic              w_timer_done;
    logic              w_enter;
    logic [2:0]        w_enter_idx;
    logic [CNT_W-1:0]  w_enter_dur;
    logic              w_burst_end;
    logic              w_next_impulse;

`ifdef LATE_CMD_DROP_EN
    assign w_late = (MEM_TIME_START < r_time);
`else
    assign w_late = 1'b0;
`endif

    assign w_unused_type = MEM_TYPE_impulse[1];

    assign w_nz    = {(r_tb2 != '0), (r_tp != '0), (r_tb1 != '0), (r_ti != '0)};
    assign w_first = next_phase(w_nz, c_PH_IZ);
    assign w_cur   = state_phase(r_state);
    assign w_after = next_phase(w_nz, w_cur + 3'd1);
    assign w_due   = (r_time >= r_start);

    // Phase sequencing: zero-length phases are skipped in the same cycle.
    always_comb begin
        w_enter        = 1'b0;
        w_enter_idx    = w_first;
        w_burst_end    = 1'b0;
        w_next_impulse = 1'b0;
        case (r_state)
            S_ARMED: begin
                if (w_due) begin
                    if (w_first == c_PH_NONE) begin
                        w_burst_end = 1'b1;
                    end else begin
                        w_enter = 1'b1;
                    end
                end
            end
            S_IZ, S_BL1, S_PR, S_BL2: begin
                if (w_timer_done) begin
                    if (w_after != c_PH_NONE) begin
                        w_enter     = 1'b1;
                        w_enter_idx = w_after;
                    end else if (r_imp_left == c_NIMP_W'(1)) begin
                        w_burst_end = 1'b1;
                    end else begin
                        w_enter        = 1'b1;
                        w_next_impulse = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_enter_dur = '0;
        case (w_enter_idx)
            c_PH_IZ:  w_enter_dur = r_ti;
            c_PH_BL1: w_enter_dur = r_tb1;
            c_PH_PR:  w_enter_dur = r_tp;
            c_PH_BL2: w_enter_dur = r_tb2;
            default:  w_enter_dur = '0;
        endcase
    end

    ms_interval_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clk         (CLK),
        .rst_n       (rst_n),
        .i_load      (w_enter),
        .i_load_value(w_enter_dur),
        .o_done      (w_timer_done)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_start          <= '0;
            r_imp_left       <= '0;
            r_coherent       <= 1'b0;
            r_ti             <= '0;
            r_tp             <= '0;
            r_tb1            <= '0;
            r_tb2            <= '0;
            r_req_command    <= 1'b0;
            r_dds_freq       <= '0;
            r_dds_delta_freq <= '0;
            r_dds_delta_rate <= '0;
            r_req            <= 1'b0;
            r_dds_start      <= 1'b0;
            r_en_iz          <= 1'b0;
            r_en_pr          <= 1'b0;
        end else begin
            r_req_command <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_req_command <= 1'b1;
                    r_state       <= S_WAIT_CMD;
                end
                S_WAIT_CMD: begin
                    if (WR_DATA) begin
                        r_start    <= MEM_TIME_START;
                        r_imp_left <= MEM_N_impuls;
                        r_coherent <= MEM_TYPE_impulse[c_TYPE_COHERENT_BIT];
                        r_ti       <= MEM_Interval_Ti;
                        r_tp       <= MEM_Interval_Tp;
                        r_tb1      <= MEM_Tblank1;
                        r_tb2      <= MEM_Tblank2;
                        if ((MEM_N_impuls == '0) || w_late) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_dds_freq       <= MEM_DDS_freq;
                            r_dds_delta_freq <= MEM_DDS_delta_freq;
                            r_dds_delta_rate <= MEM_DDS_delta_rate;
                            r_req            <= 1'b1;
                            r_state          <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_ack_sync) begin
                        r_req   <= 1'b0;
                        r_state <= S_LOAD_REL;
                    end
                end
                S_LOAD_REL: begin
                    if (!r_ack_sync) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED, S_IZ, S_BL1, S_PR, S_BL2: begin
                    if (w_burst_end) begin
                        r_state     <= S_IDLE;
                        r_en_iz     <= 1'b0;
                        r_en_pr     <= 1'b0;
                        r_dds_start <= 1'b0;
                    end else if (w_enter) begin
                        r_state     <= phase_state(w_enter_idx);
                        r_en_iz     <= (w_enter_idx == c_PH_IZ);
                        r_en_pr     <= (w_enter_idx == c_PH_PR);
                        r_dds_start <= r_coherent | (w_enter_idx == c_PH_IZ);
                        if (w_next_impulse) begin
                            r_imp_left <= r_imp_left - c_NIMP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TIME               = r_time;
    assign SYS_TIME_UPDATE_OK = r_upd_ok;
    assign REQ_COMMAND        = r_req_command;
    assign DDS_freq           = r_dds_freq;
    assign DDS_delta_freq     = r_dds_delta_freq;
    assign DDS_delta_rate     = r_dds_delta_rate;
    assign REQ                = r_req;
    assign DDS_start          = r_dds_start;
    assign En_Iz              = r_en_iz;
    assign En_Pr              = r_en_pr;

endmodule : master_start_sync
`default_nettype wire

// File: tb/tb_master_start_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_master_start_sync
// Brief   : Directed self-checking bench for master_start_sync.
// Revision: 1.0 - initial release
// ============================================================================
module tb_master_start_sync;

    logic        CLK;
    logic        rst_n;
    logic [63:0] SYS_TIME;
    logic        SYS_TIME_UPDATE;
    logic        T1hz;
    logic [63:0] TIME;
    logic        SYS_TIME_UPDATE_OK;
    logic        REQ_COMMAND;
    logic        WR_DATA;
    logic [47:0] MEM_DDS_freq;
    logic [47:0] MEM_DDS_delta_freq;
    logic [31:0] MEM_DDS_delta_rate;
    logic [63:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls;
    logic [1:0]  MEM_TYPE_impulse;
    logic [31:0] MEM_Interval_Ti;
    logic [31:0] MEM_Interval_Tp;
    logic [31:0] MEM_Tblank1;
    logic [31:0] MEM_Tblank2;
    logic [47:0] DDS_freq;
    logic [47:0] DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        REQ;
    logic        ACK;
    logic        DDS_start;
    logic        En_Iz;
    logic        En_Pr;

    int checks = 0;
    int errors = 0;
    bit ack_auto = 1'b0;

    master_start_sync dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .SYS_TIME          (SYS_TIME),
        .SYS_TIME_UPDATE   (SYS_TIME_UPDATE),
        .T1hz              (T1hz),
        .TIME              (TIME),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK),
        .REQ_COMMAND       (REQ_COMMAND),
        .WR_DATA           (WR_DATA),
        .MEM_DDS_freq      (MEM_DDS_freq),
        .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
        .MEM_DDS_delta_rate(MEM_DDS_delta_rate),
        .MEM_TIME_START    (MEM_TIME_START),
        .MEM_N_impuls      (MEM_N_impuls),
        .MEM_TYPE_impulse  (MEM_TYPE_impulse),
        .MEM_Interval_Ti   (MEM_Interval_Ti),
        .MEM_Interval_Tp   (MEM_Interval_Tp),
        .MEM_Tblank1       (MEM_Tblank1),
        .MEM_Tblank2       (MEM_Tblank2),
        .DDS_freq          (DDS_freq),
        .DDS_delta_freq    (DDS_delta_freq),
        .DDS_delta_rate    (DDS_delta_rate),
        .REQ               (REQ),
        .ACK               (ACK),
        .DDS_start         (DDS_start),
        .En_Iz             (En_Iz),
        .En_Pr             (En_Pr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // DDS model: echoes REQ onto ACK one cycle later when enabled.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (ack_auto) ACK = REQ;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        SYS_TIME = '0; SYS_TIME_UPDATE = 1'b0; T1hz = 1'b0; WR_DATA = 1'b0;
        MEM_DDS_freq = '0; MEM_DDS_delta_freq = '0; MEM_DDS_delta_rate = '0;
        MEM_TIME_START = '0; MEM_N_impuls = '0; MEM_TYPE_impulse = '0;
        MEM_Interval_Ti = '0; MEM_Interval_Tp = '0; MEM_Tblank1 = '0; MEM_Tblank2 = '0;
        ack_auto = 1'b0; ACK = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req_command(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (REQ_COMMAND === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic preload_time(input logic [63:0] value);
        T1hz = 1'b0;
        tick();
        SYS_TIME = value; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
        tick();
        T1hz = 1'b0; SYS_TIME_UPDATE = 1'b0;
    endtask

    task automatic send_cmd(input logic [47:0] f, input logic [47:0] df, input logic [31:0] rate,
                            input logic [63:0] start, input logic [15:0] n, input logic [1:0] typ,
                            input logic [31:0] ti, input logic [31:0] tp,
                            input logic [31:0] tb1, input logic [31:0] tb2);
        MEM_DDS_freq = f; MEM_DDS_delta_freq = df; MEM_DDS_delta_rate = rate;
        MEM_TIME_START = start; MEM_N_impuls = n; MEM_TYPE_impulse = typ;
        MEM_Interval_Ti = ti; MEM_Interval_Tp = tp; MEM_Tblank1 = tb1; MEM_Tblank2 = tb2;
        WR_DATA = 1'b1;
        tick();
        WR_DATA = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        apply_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (TIME !== 64'd0) begin errors++; $display("FAIL reset_time: got %h want 0", TIME); end
        checks++; if ({En_Iz, En_Pr, DDS_start, REQ, REQ_COMMAND, SYS_TIME_UPDATE_OK} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000", {En_Iz, En_Pr, DDS_start, REQ, REQ_COMMAND, SYS_TIME_UPDATE_OK});
        end
        checks++; if ({DDS_freq, DDS_delta_freq, DDS_delta_rate} !== 128'd0) begin
            errors++; $display("FAIL reset_dds: got %h want 0", {DDS_freq, DDS_delta_freq, DDS_delta_rate});
        end
        rst_n = 1'b1;
        wait_req_command(10, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL reset_req_command: got %b want 1", seen); end
        tick();
        checks++; if (REQ_COMMAND !== 1'b0) begin errors++; $display("FAIL reset_req_command_width: got %b want 0", REQ_COMMAND); end
    endtask

    task automatic test_time_preload();
        bit hit;
        preload_time(64'h4FF0);
        checks++; if (TIME !== 64'h4FF0 || SYS_TIME_UPDATE_OK !== 1'b1) begin
            errors++; $display("FAIL preload_4ff0: got TIME=%h OK=%b want 4ff0/1", TIME, SYS_TIME_UPDATE_OK);
        end
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (TIME === 64'h5000) begin hit = 1'b1; break; end
            tick();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL preload_reach_5000: got TIME=%h want 5000", TIME); end
        SYS_TIME = 64'd0; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
        tick();
        checks++; if (TIME !== 64'd0 || SYS_TIME_UPDATE_OK !== 1'b1) begin
            errors++; $display("FAIL preload_zero: got TIME=%h OK=%b want 0/1", TIME, SYS_TIME_UPDATE_OK);
        end
        SYS_TIME_UPDATE = 1'b0;
        tick();
        checks++; if (TIME !== 64'd1 || SYS_TIME_UPDATE_OK !== 1'b0) begin
            errors++; $display("FAIL preload_ok_pulse: got TIME=%h OK=%b want 1/0", TIME, SYS_TIME_UPDATE_OK);
        end
        T1hz = 1'b0;
        tick();
        SYS_TIME = 64'h1234; T1hz = 1'b1;
        tick();
        checks++; if (TIME !== 64'd3 || SYS_TIME_UPDATE_OK !== 1'b0) begin
            errors++; $display("FAIL preload_disarmed: got TIME=%h OK=%b want 3/0", TIME, SYS_TIME_UPDATE_OK);
        end
        T1hz = 1'b0;
        preload_time(64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        checks++; if (TIME !== 64'd0) begin errors++; $display("FAIL time_wrap: got %h want 0", TIME); end
    endtask

    task automatic test_burst(input bit coherent);
        longint s, ti, b1, tp, b2, per, n, rel, k, first_rise, bad_t;
        int iz_bad, pr_bad, ds_bad, overlap, req_bad, rc_good, rc_bad, iz_rises;
        logic prev_iz, exp_iz, exp_pr, exp_ds;
        bit seen, done;
        s = 64'h22C0; ti = 6144; b1 = 384; tp = 6144; b2 = 384; n = 2;
        per = ti + b1 + tp + b2;
        iz_bad = 0; pr_bad = 0; ds_bad = 0; overlap = 0; req_bad = 0;
        rc_good = 0; rc_bad = 0; iz_rises = 0; prev_iz = 1'b0; first_rise = -1; bad_t = -1;
        apply_reset();
        ack_auto = 1'b1;
        wait_req_command(10, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL burst_req_command: got %b want 1", seen); end
        send_cmd(48'h10_0000_0000, 48'h10_0000, 32'h100, 64'h22C0, 16'd2, {1'b0, coherent},
                 32'h1800, 32'h1800, 32'h180, 32'h180);
        checks++; if (REQ !== 1'b1 || DDS_freq !== 48'h10_0000_0000 || DDS_delta_freq !== 48'h10_0000
                      || DDS_delta_rate !== 32'h100) begin
            errors++; $display("FAIL burst_dds_setup: got REQ=%b F=%h DF=%h R=%h want 1/1000000000/100000/100",
                               REQ, DDS_freq, DDS_delta_freq, DDS_delta_rate);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (REQ === 1'b0) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL burst_handshake: REQ still %b want 0", REQ); end
        repeat (5) tick();
        preload_time(64'h2000);
        done = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            rel = longint'(TIME) - (s + 1);
            exp_iz = 1'b0; exp_pr = 1'b0; exp_ds = 1'b0;
            if (rel >= 0 && rel < n * per) begin
                k = rel % per;
                exp_iz = (k < ti);
                exp_pr = (k >= ti + b1) && (k < ti + b1 + tp);
                exp_ds = coherent ? 1'b1 : exp_iz;
            end
            if (En_Iz !== exp_iz) begin iz_bad++; if (bad_t < 0) bad_t = longint'(TIME); end
            if (En_Pr !== exp_pr) begin pr_bad++; if (bad_t < 0) bad_t = longint'(TIME); end
            if (DDS_start !== exp_ds) begin ds_bad++; if (bad_t < 0) bad_t = longint'(TIME); end
            if (En_Iz === 1'b1 && En_Pr === 1'b1) overlap++;
            if (REQ !== 1'b0) req_bad++;
            if (REQ_COMMAND === 1'b1) begin
                if (rel >= n * per && rel <= n * per + 4) rc_good++;
                else rc_bad++;
            end
            if (En_Iz === 1'b1 && prev_iz === 1'b0) begin
                iz_rises++;
                if (first_rise < 0) first_rise = longint'(TIME);
            end
            prev_iz = En_Iz;
            if (rel > n * per + 8) begin done = 1'b1; break; end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL burst_timeout: TIME=%h not past burst end", TIME); end
        checks++; if (first_rise !== 64'h22C1) begin errors++; $display("FAIL burst_first_rise: got TIME %h want 22c1", first_rise); end
        checks++; if (iz_bad != 0) begin errors++; $display("FAIL burst_en_iz: %0d bad cycles (first at TIME %h) want 0", iz_bad, bad_t); end
        checks++; if (pr_bad != 0) begin errors++; $display("FAIL burst_en_pr: %0d bad cycles (first at TIME %h) want 0", pr_bad, bad_t); end
        checks++; if (ds_bad != 0) begin errors++; $display("FAIL burst_dds_start: %0d bad cycles (first at TIME %h) want 0", ds_bad, bad_t); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL burst_overlap: got %0d want 0", overlap); end
        checks++; if (req_bad != 0) begin errors++; $display("FAIL burst_no_req: got %0d REQ cycles want 0", req_bad); end
        checks++; if (iz_rises != 2) begin errors++; $display("FAIL burst_impulses: got %0d want 2", iz_rises); end
        checks++; if (rc_good != 1 || rc_bad != 0) begin
            errors++; $display("FAIL burst_req_command_after: got good=%0d bad=%0d want 1/0", rc_good, rc_bad);
        end
    endtask

    task automatic test_handshake_stall();
        logic [63:0] t0;
        bit seen;
        int bad, early;
        int iz_bad, pr_bad, ds_bad;
        logic e_iz, e_pr, e_ds;
        apply_reset();
        wait_req_command(10, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_req_command: got %b want 1", seen); end
        t0 = TIME;
        send_cmd(48'hABCD_EF01_2345, 48'h1, 32'h55, t0 + 64'd120, 16'd2, 2'b01, 32'd4, 32'd3, 32'd0, 32'd0);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (REQ !== 1'b1 || DDS_freq !== 48'hABCD_EF01_2345 || DDS_delta_freq !== 48'h1
                || DDS_delta_rate !== 32'h55) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_req_stable: %0d unstable cycles want 0", bad); end
        ACK = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (REQ === 1'b0) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_req_release: REQ %b want 0", REQ); end
        early = 0;
        for (int c = 0; c < 100; c++) begin
            if (En_Iz !== 1'b0 || DDS_start !== 1'b0) early++;
            tick();
        end
        checks++; if (early != 0) begin errors++; $display("FAIL stall_armed_early: %0d cycles active want 0", early); end
        ACK = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (En_Iz === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_start: En_Iz %b want 1", En_Iz); end
        // Ti=4, Tp=3, both blanks zero, two impulses: IIIIPPPIIIIPPP then idle.
        iz_bad = 0; pr_bad = 0; ds_bad = 0;
        for (int c = 0; c < 16; c++) begin
            e_iz = (c < 4) || (c >= 7 && c < 11);
            e_pr = (c >= 4 && c < 7) || (c >= 11 && c < 14);
            e_ds = (c < 14);
            if (En_Iz !== e_iz) iz_bad++;
            if (En_Pr !== e_pr) pr_bad++;
            if (DDS_start !== e_ds) ds_bad++;
            tick();
        end
        checks++; if (iz_bad != 0) begin errors++; $display("FAIL skip_en_iz: %0d bad cycles want 0", iz_bad); end
        checks++; if (pr_bad != 0) begin errors++; $display("FAIL skip_en_pr: %0d bad cycles want 0", pr_bad); end
        checks++; if (ds_bad != 0) begin errors++; $display("FAIL skip_dds_start: %0d bad cycles want 0", ds_bad); end
    endtask

    task automatic test_zero_count();
        bit seen;
        int req_seen;
        apply_reset();
        ack_auto = 1'b1;
        wait_req_command(10, seen);
        send_cmd(48'h1, 48'h1, 32'h1, 64'h100, 16'd0, 2'b01, 32'd5, 32'd5, 32'd1, 32'd1);
        seen = 1'b0; req_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (REQ === 1'b1) req_seen++;
            if (REQ_COMMAND === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_n_rerequest: got %b want 1", seen); end
        checks++; if (req_seen != 0) begin errors++; $display("FAIL zero_n_no_req: got %0d want 0", req_seen); end
    endtask

    task automatic test_late_command();
        bit seen;
        int iz_cnt, req_cnt, rc_cnt;
        apply_reset();
        ack_auto = 1'b1;
        wait_req_command(10, seen);
        preload_time(64'h9000);
        send_cmd(48'h2, 48'h2, 32'h2, 64'h10, 16'd1, 2'b01, 32'd5, 32'd5, 32'd1, 32'd1);
        iz_cnt = 0; req_cnt = 0; rc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (En_Iz === 1'b1) iz_cnt++;
            if (REQ === 1'b1) req_cnt++;
            if (REQ_COMMAND === 1'b1) rc_cnt++;
            tick();
        end
`ifdef LATE_CMD_DROP_EN
        checks++; if (iz_cnt != 0) begin errors++; $display("FAIL late_drop_en_iz: got %0d cycles want 0", iz_cnt); end
        checks++; if (req_cnt != 0) begin errors++; $display("FAIL late_drop_req: got %0d cycles want 0", req_cnt); end
        checks++; if (rc_cnt != 1) begin errors++; $display("FAIL late_drop_rerequest: got %0d want 1", rc_cnt); end
`else
        checks++; if (req_cnt == 0) begin errors++; $display("FAIL late_run_req: got %0d cycles want >0", req_cnt); end
        checks++; if (iz_cnt != 5) begin errors++; $display("FAIL late_run_en_iz: got %0d cycles want 5", iz_cnt); end
        checks++; if (rc_cnt != 1) begin errors++; $display("FAIL late_run_rerequest: got %0d want 1", rc_cnt); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] t0;
        bit seen;
        apply_reset();
        ack_auto = 1'b1;
        wait_req_command(10, seen);
        t0 = TIME;
        send_cmd(48'h3, 48'h3, 32'h3, t0 + 64'd40, 16'd3, 2'b01, 32'd100, 32'd10, 32'd5, 32'd5);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (En_Iz === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_iz_start: En_Iz %b want 1", En_Iz); end
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({En_Iz, En_Pr, DDS_start, REQ} !== 4'b0) begin
            errors++; $display("FAIL mid_iz_async_reset: got %b want 0000", {En_Iz, En_Pr, DDS_start, REQ});
        end
        tick(); tick();
        rst_n = 1'b1;
        ack_auto = 1'b0; ACK = 1'b0;
        wait_req_command(10, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_iz_rerequest: got %b want 1", seen); end
        send_cmd(48'h4, 48'h4, 32'h4, 64'hFFFF, 16'd1, 2'b01, 32'd5, 32'd5, 32'd1, 32'd1);
        checks++; if (REQ !== 1'b1) begin errors++; $display("FAIL load_req_raised: got %b want 1", REQ); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (REQ !== 1'b0) begin errors++; $display("FAIL load_async_release: got %b want 0", REQ); end
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_time_preload();
        test_burst(1'b1);
        test_burst(1'b0);
        test_handshake_stall();
        test_zero_count();
        test_late_command();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_master_start_sync
`default_nettype wire
